mem_access_stage: RTL and testbench

Memory-access stage of the 5-stage pipelined CPU, sitting between the EX/MEM pipeline register and writeback. It consumes the M-stage control and data (ALU result, store data, destination register) and drives a variable-latency data-memory port through a req/ack handshake. While an access is outstanding it stalls the upstream pipeline. It also provides the registered MEM/WB boundary that feeds the register-file write port.

---
 rtl/mem_access_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access (M) stage of the 5-stage pipeline.
//
// Takes the M-stage control/data from the EX/MEM register, drives a variable-latency data memory
// through a req/ack handshake, stalls the upstream pipeline while an access is outstanding, and
// holds the MEM/WB boundary register that feeds the register-file write port.
//
// Optional feature: define MEM_TIMEOUT_EN to build a watchdog that force-completes an access
// (as a bubble) after TIMEOUT_CYCLES BUSY cycles without ack and sets the sticky mem_err flag.
// Without the macro no counter is built, BUSY waits indefinitely and mem_err is tied to 0.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   RegWriteM, MemToRegM, MemWriteM M-stage control bits
//   ALUOutM, DbM, RdM               address/result, store data, destination register
//   mem_req, mem_we                 memory request valid, 1 = store / 0 = load
//   mem_addr, mem_wdata             memory address (ALUOutM), store data (DbM)
//   mem_ack, mem_rdata              access complete, load data (valid with ack)
//   StallM                          hold EX/MEM and all earlier stages
//   RegWriteW, MemToRegW            W-stage control bits (registered)
//   ReadDataW, ALUOutW, RdW         W-stage data (registered)
//   mem_err                         sticky watchdog flag

module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        RegWriteM,
    input  logic        MemToRegM,
    input  logic        MemWriteM,
    input  logic [63:0] ALUOutM,
    input  logic [63:0] DbM,
    input  logic [4:0]  RdM,

    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,

    output logic        StallM,

    output logic        RegWriteW,
    output logic        MemToRegW,
    output logic [63:0] ReadDataW,
    output logic [63:0] ALUOutW,
    output logic [4:0]  RdW,

    output logic        mem_err
);

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    state_e state_q;

    logic mem_op;
    logic busy;
    logic timeout_fire;

    assign mem_op = MemToRegM | MemWriteM;
    assign busy   = (state_q == StBusy);

`ifdef MEM_TIMEOUT_EN
    // Counter holds the number of ack-less BUSY cycles already completed; it only needs to reach
    // TIMEOUT_CYCLES-1 because the firing cycle itself is the last one counted.
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] cnt_q;
    logic            err_q;

    assign timeout_fire = busy & ~mem_ack & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign mem_err      = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            // Cleared while IDLE so every BUSY episode starts counting from zero.
            if (!busy || mem_ack || timeout_fire) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (timeout_fire) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_fire       = 1'b0;
    assign mem_err            = 1'b0;
`endif

    // Memory port and stall are purely combinational from state and M inputs; mem_ack only feeds
    // StallM, never mem_req.
    always_comb begin
        mem_req   = busy;
        mem_we    = busy & MemWriteM;
        mem_addr  = ALUOutM;
        mem_wdata = DbM;
        if (busy) begin
            StallM = ~(mem_ack | timeout_fire);
        end else begin
            StallM = mem_op;
        end
    end

    // FSM plus MEM/WB register. Every path not explicitly capturing an op writes a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            RegWriteW <= 1'b0;
            MemToRegW <= 1'b0;
            ReadDataW <= '0;
            ALUOutW   <= '0;
            RdW       <= '0;
        end else begin
            RegWriteW <= 1'b0;
            MemToRegW <= 1'b0;
            ReadDataW <= '0;
            ALUOutW   <= '0;
            RdW       <= '0;
            case (state_q)
                StIdle: begin
                    if (mem_op) begin
                        state_q <= StBusy;
                    end else begin
                        RegWriteW <= RegWriteM;
                        ALUOutW   <= ALUOutM;
                        RdW       <= RdM;
                    end
                end
                StBusy: begin
                    if (mem_ack) begin
                        state_q   <= StIdle;
                        RegWriteW <= RegWriteM;
                        MemToRegW <= MemToRegM;
                        ReadDataW <= MemWriteM ? 64'd0 : mem_rdata;
                        ALUOutW   <= ALUOutM;
                        RdW       <= RdM;
                    end else if (timeout_fire) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, a reset-during-BUSY sequence,
// a randomized op stream checked against a per-op timeline model, and (when MEM_TIMEOUT_EN is
// defined) the watchdog sequence.

module tb_mem_access_stage;

    localparam int unsigned TbTimeout = 4;

    logic        clk;
    logic        reset;
    logic        RegWriteM, MemToRegM, MemWriteM;
    logic [63:0] ALUOutM, DbM;
    logic [4:0]  RdM;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        StallM;
    logic        RegWriteW, MemToRegW;
    logic [63:0] ReadDataW, ALUOutW;
    logic [4:0]  RdW;
    logic        mem_err;

    mem_access_stage #(
        .TIMEOUT_CYCLES(TbTimeout)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .RegWriteM (RegWriteM),
        .MemToRegM (MemToRegM),
        .MemWriteM (MemWriteM),
        .ALUOutM   (ALUOutM),
        .DbM       (DbM),
        .RdM       (RdM),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .StallM    (StallM),
        .RegWriteW (RegWriteW),
        .MemToRegW (MemToRegW),
        .ReadDataW (ReadDataW),
        .ALUOutW   (ALUOutW),
        .RdW       (RdW),
        .mem_err   (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst;
        logic        rw, mtr, mw;
        logic [63:0] alu, db;
        logic [4:0]  rd;
        logic        ack;
        logic [63:0] rdata;
        logic        e_stall, e_req, e_we;
        logic        e_rw, e_mtr;
        logic [63:0] e_rdat, e_alu;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t vecs[16];

    task automatic expect_eq(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic rw, input logic mtr, input logic mw,
                         input logic [63:0] alu, input logic [63:0] db, input logic [4:0] rd,
                         input logic ack, input logic [63:0] rdata);
        reset     = rst;
        RegWriteM = rw;
        MemToRegM = mtr;
        MemWriteM = mw;
        ALUOutM   = alu;
        DbM       = db;
        RdM       = rd;
        mem_ack   = ack;
        mem_rdata = rdata;
    endtask

    // Call after drive(); waits #1 then checks the combinational outputs of the current cycle.
    task automatic chk_comb(input string name, input logic e_stall, input logic e_req,
                            input logic e_we, input logic [63:0] alu, input logic [63:0] db);
        #1;
        expect_eq({name, " stall/req"}, {StallM, mem_req}, {e_stall, e_req});
        if (e_req) begin
            expect_eq({name, " we/addr/wdata"}, {mem_we, mem_addr, mem_wdata}, {e_we, alu, db});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string name, input logic rw, input logic mtr,
                         input logic [63:0] rdat, input logic [63:0] alu, input logic [4:0] rd);
        expect_eq({name, " W"}, {RegWriteW, MemToRegW, ReadDataW, ALUOutW, RdW},
                  {rw, mtr, rdat, alu, rd});
    endtask

    function automatic vec_t mk(input logic rw, input logic mtr, input logic mw,
                                input logic [63:0] alu, input logic [63:0] db, input logic [4:0] rd,
                                input logic ack, input logic [63:0] rdata,
                                input logic e_stall, input logic e_req, input logic e_we,
                                input logic e_rw, input logic e_mtr, input logic [63:0] e_rdat,
                                input logic [63:0] e_alu, input logic [4:0] e_rd);
        vec_t v;
        v.rst = 1'b0; v.rw = rw; v.mtr = mtr; v.mw = mw; v.alu = alu; v.db = db; v.rd = rd;
        v.ack = ack; v.rdata = rdata; v.e_stall = e_stall; v.e_req = e_req; v.e_we = e_we;
        v.e_rw = e_rw; v.e_mtr = e_mtr; v.e_rdat = e_rdat; v.e_alu = e_alu; v.e_rd = e_rd;
        return v;
    endfunction

    // Random op stream. Each op occupies M for a known number of cycles: 1 for an ALU op,
    // 2 + wait for a memory op. The model derives every expected value from the op's position
    // in that timeline.
    task automatic run_random(input int n_ops);
        for (int n = 0; n < n_ops; n++) begin
            int          kind;
            int          w;
            int          d;
            logic        is_mem, is_ld, is_st, rw, last, ack;
            logic [63:0] alu, db, rdat;
            logic [4:0]  rd;
            kind   = $urandom_range(0, 2);
            w      = $urandom_range(0, 2);
            is_ld  = (kind == 1);
            is_st  = (kind == 2);
            is_mem = is_ld | is_st;
            rw     = is_ld ? 1'b1 : (is_st ? 1'b0 : 1'($urandom_range(0, 1)));
            alu    = {$urandom, $urandom};
            db     = {$urandom, $urandom};
            rd     = 5'($urandom);
            d      = is_mem ? 2 + w : 1;
            for (int i = 0; i < d; i++) begin
                last = (i == d - 1);
                if (is_mem && i > 0) begin
                    ack = last;
                end else begin
                    // Stray acks outside BUSY must be ignored.
                    ack = ($urandom_range(0, 3) == 0);
                end
                rdat = {$urandom, $urandom};
                drive(1'b0, rw, is_ld, is_st, alu, db, rd, ack, rdat);
                chk_comb("rand", !last, is_mem && (i > 0), is_st, alu, db);
                tick();
                if (last) begin
                    chk_w("rand retire", rw, is_ld, is_ld ? rdat : 64'd0, alu, rd);
                end else begin
                    chk_w("rand bubble", 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
                end
                expect_eq("rand mem_err", mem_err, 1'b0);
            end
        end
    endtask

    initial begin
        // Directed table: each row is one cycle; W expectation is the state after that edge.
        vecs[0]  = mk(1, 0, 0, 64'h1234, 0, 5'd5, 0, 0,
                      0, 0, 0, 1, 0, 0, 64'h1234, 5'd5);
        vecs[1]  = mk(1, 1, 0, 64'h40, 0, 5'd7, 0, 0,
                      1, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 64'h40, 0, 5'd7, 1, 64'hDEADBEEF,
                      0, 1, 0, 1, 1, 64'hDEADBEEF, 64'h40, 5'd7);
        vecs[3]  = mk(0, 0, 1, 64'h80, 64'h77, 5'd0, 0, 0,
                      1, 0, 1, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 1, 64'h80, 64'h77, 5'd0, 0, 0,
                      1, 1, 1, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 1, 64'h80, 64'h77, 5'd0, 0, 64'h1111,
                      1, 1, 1, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 1, 64'h80, 64'h77, 5'd0, 0, 0,
                      1, 1, 1, 0, 0, 0, 0, 0);
        vecs[7]  = mk(0, 0, 1, 64'h80, 64'h77, 5'd0, 1, 64'h5555,
                      0, 1, 1, 0, 0, 0, 64'h80, 5'd0);
        vecs[8]  = mk(1, 1, 0, 64'h100, 0, 5'd3, 0, 0,
                      1, 0, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(1, 1, 0, 64'h100, 0, 5'd3, 1, 64'h11,
                      0, 1, 0, 1, 1, 64'h11, 64'h100, 5'd3);
        vecs[10] = mk(1, 1, 0, 64'h108, 0, 5'd4, 0, 0,
                      1, 0, 0, 0, 0, 0, 0, 0);
        vecs[11] = mk(1, 1, 0, 64'h108, 0, 5'd4, 1, 64'h22,
                      0, 1, 0, 1, 1, 64'h22, 64'h108, 5'd4);
        vecs[12] = mk(1, 0, 0, 64'hABC, 0, 5'd9, 1, 64'hFFFF,
                      0, 0, 0, 1, 0, 0, 64'hABC, 5'd9);
        vecs[13] = mk(1, 1, 0, 64'h200, 0, 5'd10, 1, 64'h99,
                      1, 0, 0, 0, 0, 0, 0, 0);
        vecs[14] = mk(1, 1, 0, 64'h200, 0, 5'd10, 0, 64'h98,
                      1, 1, 0, 0, 0, 0, 0, 0);
        vecs[15] = mk(1, 1, 0, 64'h200, 0, 5'd10, 1, 64'h123456789ABCDEF0,
                      0, 1, 0, 1, 1, 64'h123456789ABCDEF0, 64'h200, 5'd10);

        // Reset state.
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_w("reset", 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        expect_eq("reset req/stall/err", {mem_req, StallM, mem_err}, 3'b000);

        for (int k = 0; k < 16; k++) begin
            string nm;
            nm = $sformatf("vec%0d", k);
            drive(vecs[k].rst, vecs[k].rw, vecs[k].mtr, vecs[k].mw, vecs[k].alu, vecs[k].db,
                  vecs[k].rd, vecs[k].ack, vecs[k].rdata);
            chk_comb(nm, vecs[k].e_stall, vecs[k].e_req, vecs[k].e_we, vecs[k].alu, vecs[k].db);
            tick();
            chk_w(nm, vecs[k].e_rw, vecs[k].e_mtr, vecs[k].e_rdat, vecs[k].e_alu, vecs[k].e_rd);
        end

        // Reset in the second BUSY cycle aborts the access.
        drive(1'b0, 1, 1, 0, 64'h300, 0, 5'd12, 0, 0);
        chk_comb("abort issue", 1'b1, 1'b0, 1'b0, 64'h300, 64'd0);
        tick();
        drive(1'b0, 1, 1, 0, 64'h300, 0, 5'd12, 0, 0);
        chk_comb("abort busy1", 1'b1, 1'b1, 1'b0, 64'h300, 64'd0);
        tick();
        drive(1'b1, 1, 1, 0, 64'h300, 0, 5'd12, 0, 0);
        chk_comb("abort busy2", 1'b1, 1'b1, 1'b0, 64'h300, 64'd0);
        tick();
        expect_eq("abort req", mem_req, 1'b0);
        chk_w("abort", 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        // An ALU op now passes with no stall, which only happens from IDLE.
        drive(1'b0, 1, 0, 0, 64'h55, 0, 5'd2, 0, 0);
        chk_comb("after abort", 1'b0, 1'b0, 1'b0, 64'h55, 64'd0);
        tick();
        chk_w("after abort", 1'b1, 1'b0, 64'd0, 64'h55, 5'd2);

        run_random(300);

`ifdef MEM_TIMEOUT_EN
        drive(1'b0, 1, 1, 0, 64'h400, 0, 5'd6, 0, 0);
        chk_comb("to issue", 1'b1, 1'b0, 1'b0, 64'h400, 64'd0);
        tick();
        for (int k = 1; k <= int'(TbTimeout); k++) begin
            chk_comb($sformatf("to busy%0d", k), k < int'(TbTimeout), 1'b1, 1'b0,
                     64'h400, 64'd0);
            tick();
            expect_eq($sformatf("to err%0d", k), mem_err, k == int'(TbTimeout));
            chk_w("to bubble", 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        end
        drive(1'b0, 1, 0, 0, 64'h66, 0, 5'd8, 0, 0);
        chk_comb("to after", 1'b0, 1'b0, 1'b0, 64'h66, 64'd0);
        tick();
        chk_w("to after", 1'b1, 1'b0, 64'd0, 64'h66, 5'd8);
        expect_eq("to sticky", mem_err, 1'b1);
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expect_eq("to reset clears", mem_err, 1'b0);
        drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
